// File: rtl/coco_timer_mc.sv
// Multi-channel COCO down-counter timer: NCH channels behind one word-addressed bus slave,
// one-shot / periodic auto-reload modes, sticky W1C pending flags merged into a single IRQ.
module coco_timer_mc #(
    parameter int NCH = 2,
    parameter int CW  = 32,
    parameter int CSW = 3
) (
    input  logic           CLK_I,
    input  logic           RSTN_I,
    input  logic [CSW+3:2] ADD_I,
    input  logic           WE_I,
    input  logic [31:0]    DAT_I,
    output logic [31:0]    DAT_O,
    output logic           IRQ
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] REG_CTRL      = 2'd0;
    localparam logic [1:0] REG_PRESET    = 2'd1;
    localparam logic [1:0] REG_COUNT     = 2'd2;
    localparam logic [1:0] REG_STATUS    = 2'd3;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

    logic [1:0]     reg_sel_s;
    logic [CSW-1:0] ch_sel_s;
    logic [NCH-1:0] ch_hit_s;
    logic [NCH-1:0] wr_ctrl_s;
    logic [NCH-1:0] wr_preset_s;
    logic [NCH-1:0] wr_clr_s;

    logic [3:0]     ctrl_q   [NCH];
    logic [3:0]     ctrl_d   [NCH];
    logic [CW-1:0]  preset_q [NCH];
    logic [CW-1:0]  preset_d [NCH];
    logic [CW-1:0]  count_q  [NCH];
    logic [CW-1:0]  count_d  [NCH];
    state_e         state_q  [NCH];
    state_e         state_d  [NCH];
    logic [NCH-1:0] pend_q;
    logic [NCH-1:0] pend_d;

    logic [31:0]    chan_rd_s [NCH];
    logic [31:0]    rdata_s;
    logic           irq_s;

    assign reg_sel_s = ADD_I[3:2];
    assign ch_sel_s  = ADD_I[CSW+3:4];

    // Address decode; a channel select with no matching channel hits nothing.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ch_hit_s[i]    = (ch_sel_s == CSW'(i));
            wr_ctrl_s[i]   = WE_I && ch_hit_s[i] && (reg_sel_s == REG_CTRL);
            wr_preset_s[i] = WE_I && ch_hit_s[i] && (reg_sel_s == REG_PRESET);
            wr_clr_s[i]    = WE_I && ch_hit_s[i] && (reg_sel_s == REG_STATUS) && DAT_I[0];
        end
    end

    // Per-channel next state; decisions use the enable as written this cycle, so a
    // disable freezes COUNT at the value visible during the write.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ctrl_d[i]   = wr_ctrl_s[i] ? DAT_I[3:0] : ctrl_q[i];
            preset_d[i] = wr_preset_s[i] ? DAT_I[CW-1:0] : preset_q[i];
            count_d[i]  = count_q[i];
            state_d[i]  = state_q[i];
            pend_d[i]   = pend_q[i] & ~wr_clr_s[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (ctrl_d[i][0]) state_d[i] = ST_LOAD;
                    else              state_d[i] = ST_IDLE;
                end
                ST_LOAD: begin
                    if (!ctrl_d[i][0]) begin
                        state_d[i] = ST_IDLE;
                    end else begin
                        count_d[i] = preset_q[i];
                        if (preset_q[i] != {CW{1'b0}}) state_d[i] = ST_CNT;
                        else                           state_d[i] = ST_LOAD;
                    end
                end
                ST_CNT: begin
                    if (!ctrl_d[i][0]) begin
                        state_d[i] = ST_IDLE;
                    end else if (count_q[i] > CW'(1)) begin
                        count_d[i] = count_q[i] - CW'(1);
                    end else begin
                        // Terminal event overrides a same-cycle W1C.
                        count_d[i] = {CW{1'b0}};
                        pend_d[i]  = 1'b1;
                        if (ctrl_d[i][2:1] == MODE_PERIODIC) state_d[i] = ST_LOAD;
                        else                                 state_d[i] = ST_DONE;
                    end
                end
                ST_DONE: begin
                    count_d[i] = {CW{1'b0}};
                    if (!ctrl_d[i][0])       state_d[i] = ST_IDLE;
                    else if (wr_preset_s[i]) state_d[i] = ST_LOAD;
                    else                     state_d[i] = ST_DONE;
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase
        end
    end

    // Channel state registers.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            for (int i = 0; i < NCH; i++) begin
                ctrl_q[i]   <= 4'd0;
                preset_q[i] <= {CW{1'b0}};
                count_q[i]  <= {CW{1'b0}};
                state_q[i]  <= ST_IDLE;
            end
            pend_q <= {NCH{1'b0}};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                ctrl_q[i]   <= ctrl_d[i];
                preset_q[i] <= preset_d[i];
                count_q[i]  <= count_d[i];
                state_q[i]  <= state_d[i];
            end
            pend_q <= pend_d;
        end
    end

    // Read mux and interrupt merge, both straight from registered state.
    always_comb begin
        rdata_s = 32'd0;
        irq_s   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            case (reg_sel_s)
                REG_CTRL:   chan_rd_s[i] = 32'(ctrl_q[i]);
                REG_PRESET: chan_rd_s[i] = 32'(preset_q[i]);
                REG_COUNT:  chan_rd_s[i] = 32'(count_q[i]);
                REG_STATUS: chan_rd_s[i] = 32'(pend_q[i]);
                default:    chan_rd_s[i] = 32'd0;
            endcase
            rdata_s = rdata_s | (ch_hit_s[i] ? chan_rd_s[i] : 32'd0);
            irq_s   = irq_s | (pend_q[i] & ctrl_q[i][3]);
        end
    end

    assign DAT_O = rdata_s;
    assign IRQ   = irq_s;

endmodule
